// File: rtl/riscv_core_trap_ctrl.sv
// Machine-mode trap sequencer at the commit boundary: decodes ECALL/EBREAK/MRET/WFI, arbitrates against
// exceptions and interrupts, then sequences CSR save, flush and redirect. Optional macro: TRAP_CTRL_VECTORED_EN.
module riscv_core_trap_ctrl #(
    parameter int XLEN    = 64,
    parameter int NUM_IRQ = 16
) (
    input  logic               i_trap_clk,
    input  logic               i_trap_rst_n,
    input  logic               i_trap_instr_valid,
    input  logic [31:0]        i_trap_instr,
    input  logic [XLEN-1:0]    i_trap_pc,
    input  logic               i_trap_exc_valid,
    input  logic [3:0]         i_trap_exc_cause,
    input  logic [XLEN-1:0]    i_trap_exc_tval,
    input  logic [NUM_IRQ-1:0] i_trap_irq_pending,
    input  logic [NUM_IRQ-1:0] i_trap_irq_enable,
    input  logic               i_trap_mstatus_mie,
    input  logic [XLEN-1:0]    i_trap_mtvec,
    input  logic [XLEN-1:0]    i_trap_mepc,
    output logic               o_trap_stall,
    output logic               o_trap_flush,
    output logic               o_trap_redirect_valid,
    output logic [XLEN-1:0]    o_trap_redirect_pc,
    output logic               o_trap_csr_we,
    output logic [XLEN-1:0]    o_trap_mepc,
    output logic [XLEN-1:0]    o_trap_mcause,
    output logic [XLEN-1:0]    o_trap_mtval,
    output logic               o_trap_mstatus_enter,
    output logic               o_trap_mstatus_exit,
    output logic               o_trap_sleeping
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_SLEEP    = 2'd3
    } state_e;

    function automatic logic [IDX_W-1:0] highest_idx(input logic [NUM_IRQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    state_e            state_q, state_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mtval_q, mtval_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic              event_s;

    logic              csr_we_q, enter_q, exit_q, redirect_q, sleeping_q;
    logic [XLEN-1:0]   rpc_q, out_mepc_q, out_mcause_q, out_mtval_q;

    logic [NUM_IRQ-1:0] irq_active_s;
    logic               irq_hit_s, irq_take_s;
    logic [IDX_W-1:0]   irq_idx_s;
    logic [XLEN-1:0]    irq_cause_s;
    logic [XLEN-1:0]    vec_base_s, irq_vec_s, mret_tgt_s, pc_plus4_s;
    logic               unused_s;

    assign irq_active_s = i_trap_irq_pending & i_trap_irq_enable;
    assign irq_hit_s    = |irq_active_s;
    assign irq_take_s   = irq_hit_s & i_trap_mstatus_mie;
    assign irq_idx_s    = highest_idx(irq_active_s);
    assign irq_cause_s  = {1'b1, {(XLEN-1-IDX_W){1'b0}}, irq_idx_s};
    assign vec_base_s   = {i_trap_mtvec[XLEN-1:2], 2'b00};
    assign mret_tgt_s   = {i_trap_mepc[XLEN-1:2], 2'b00};
    assign pc_plus4_s   = i_trap_pc + {{(XLEN-3){1'b0}}, 3'd4};

`ifdef TRAP_CTRL_VECTORED_EN
    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign irq_vec_s = (i_trap_mtvec[1:0] == 2'b01) ? (vec_base_s + (XLEN'(irq_idx_s) << 2)) : vec_base_s;
    assign unused_s  = ^i_trap_mepc[1:0];
`else
    assign irq_vec_s = vec_base_s;
    assign unused_s  = ^{i_trap_mtvec[1:0], i_trap_mepc[1:0]};
`endif

    assign o_trap_stall = (state_q != ST_IDLE) | event_s;

    // Event arbitration and next-state selection.
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        tgt_d    = tgt_q;
        event_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_trap_instr_valid) begin
                    if (irq_take_s) begin
                        event_s  = 1'b1;
                        state_d  = ST_SAVE;
                        mepc_d   = i_trap_pc;
                        mcause_d = irq_cause_s;
                        mtval_d  = {XLEN{1'b0}};
                        tgt_d    = irq_vec_s;
                    end else if (i_trap_exc_valid) begin
                        event_s  = 1'b1;
                        state_d  = ST_SAVE;
                        mepc_d   = i_trap_pc;
                        mcause_d = {{(XLEN-4){1'b0}}, i_trap_exc_cause};
                        mtval_d  = i_trap_exc_tval;
                        tgt_d    = vec_base_s;
                    end else if (i_trap_instr == INSTR_ECALL) begin
                        event_s  = 1'b1;
                        state_d  = ST_SAVE;
                        mepc_d   = i_trap_pc;
                        mcause_d = {{(XLEN-4){1'b0}}, 4'd11};
                        mtval_d  = {XLEN{1'b0}};
                        tgt_d    = vec_base_s;
                    end else if (i_trap_instr == INSTR_EBREAK) begin
                        event_s  = 1'b1;
                        state_d  = ST_SAVE;
                        mepc_d   = i_trap_pc;
                        mcause_d = {{(XLEN-4){1'b0}}, 4'd3};
                        mtval_d  = i_trap_pc;
                        tgt_d    = vec_base_s;
                    end else if (i_trap_instr == INSTR_MRET) begin
                        event_s  = 1'b1;
                        state_d  = ST_REDIRECT;
                        tgt_d    = mret_tgt_s;
                    end else if (i_trap_instr == INSTR_WFI) begin
                        // The wake-up interrupt returns past the WFI, so its mepc is captured now.
                        event_s  = 1'b1;
                        state_d  = ST_SLEEP;
                        mepc_d   = pc_plus4_s;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            ST_SLEEP: begin
                if (irq_take_s) begin
                    state_d  = ST_SAVE;
                    mcause_d = irq_cause_s;
                    mtval_d  = {XLEN{1'b0}};
                    tgt_d    = irq_vec_s;
                end else if (irq_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured trap context.
    always_ff @(posedge i_trap_clk or negedge i_trap_rst_n) begin
        if (!i_trap_rst_n) begin
            state_q  <= ST_IDLE;
            mepc_q   <= {XLEN{1'b0}};
            mcause_q <= {XLEN{1'b0}};
            mtval_q  <= {XLEN{1'b0}};
            tgt_q    <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            tgt_q    <= tgt_d;
        end
    end

    // Output registers decoded from the upcoming state; data buses read zero outside their strobe.
    always_ff @(posedge i_trap_clk or negedge i_trap_rst_n) begin
        if (!i_trap_rst_n) begin
            csr_we_q     <= 1'b0;
            enter_q      <= 1'b0;
            exit_q       <= 1'b0;
            redirect_q   <= 1'b0;
            sleeping_q   <= 1'b0;
            rpc_q        <= {XLEN{1'b0}};
            out_mepc_q   <= {XLEN{1'b0}};
            out_mcause_q <= {XLEN{1'b0}};
            out_mtval_q  <= {XLEN{1'b0}};
        end else begin
            csr_we_q     <= (state_d == ST_SAVE);
            enter_q      <= (state_d == ST_SAVE);
            exit_q       <= (state_q == ST_IDLE) && (state_d == ST_REDIRECT);
            redirect_q   <= (state_d == ST_REDIRECT);
            sleeping_q   <= (state_d == ST_SLEEP);
            rpc_q        <= (state_d == ST_REDIRECT) ? tgt_d : {XLEN{1'b0}};
            out_mepc_q   <= (state_d == ST_SAVE) ? mepc_d : {XLEN{1'b0}};
            out_mcause_q <= (state_d == ST_SAVE) ? mcause_d : {XLEN{1'b0}};
            out_mtval_q  <= (state_d == ST_SAVE) ? mtval_d : {XLEN{1'b0}};
        end
    end

    assign o_trap_csr_we         = csr_we_q;
    assign o_trap_mstatus_enter  = enter_q;
    assign o_trap_mstatus_exit   = exit_q;
    assign o_trap_redirect_valid = redirect_q;
    assign o_trap_flush          = redirect_q;
    assign o_trap_redirect_pc    = rpc_q;
    assign o_trap_sleeping       = sleeping_q;
    assign o_trap_mepc           = out_mepc_q;
    assign o_trap_mcause         = out_mcause_q;
    assign o_trap_mtval          = out_mtval_q;

endmodule
